blink_code_sequencer: RTL

- Downstream consumer of the timer's one-cycle interrupt pulse.
- Replaces the simple toggle-on-interrupt LED logic with a blink-code generator: emits N LED blinks, holds a gap, then repeats while enabled.
- Time base is entirely the incoming tick; the block has no prescaler of its own.
- Used for status/error codes on a single board LED.

---
 rtl/blink_code_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/blink_code_sequencer.sv
// Blink-code sequencer: turns a stream of one-cycle timer ticks into
// repeating frames of N LED blinks followed by a longer dark gap.
// All timing comes from tick_i; the block has no prescaler of its own.
// The last blink of a frame runs straight into the gap, so a frame lasts
// N*ON + (N-1)*OFF + GAP ticks.

module blink_code_sequencer #(
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned GAP_TICKS = 6,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             led_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] blink_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Terminal values of the 8-bit tick counter for each phase.
    localparam logic [7:0] ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0] OFF_LAST = 8'(OFF_TICKS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    state_t             state_q;
    logic [7:0]         tick_cnt_q;
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   blink_idx_q;
    logic               led_q;
    logic               busy_q;
    logic               frame_done_q;

    logic [7:0]         tick_cnt_d;
    logic [CNT_W-1:0]   blink_idx_d;
    logic               last_blink;
    logic               start_req;

    // Incremented values and frame-level decode shared by the FSM.
    always_comb begin
        tick_cnt_d  = tick_cnt_q + 8'd1;
        blink_idx_d = blink_idx_q + CNT_W'(1);
        last_blink  = (blink_idx_q == total_q - CNT_W'(1));
        start_req   = enable_i && (count_i != '0);
    end

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            total_q      <= '0;
            blink_idx_q  <= '0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    led_q <= 1'b0;
                    // A tick arriving with the start request is not counted:
                    // the counter is cleared on the way into ON.
                    if (start_req) begin
                        total_q     <= count_i;
                        tick_cnt_q  <= '0;
                        blink_idx_q <= '0;
                        led_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ON;
                    end
                end

                ST_ON: begin
                    if (tick_i) begin
                        if (tick_cnt_q == ON_LAST) begin
                            tick_cnt_q <= '0;
                            led_q      <= 1'b0;
                            // The final blink's dark time is the gap itself.
                            state_q    <= last_blink ? ST_GAP : ST_OFF;
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end

                ST_OFF: begin
                    if (tick_i) begin
                        if (tick_cnt_q == OFF_LAST) begin
                            tick_cnt_q  <= '0;
                            blink_idx_q <= blink_idx_d;
                            led_q       <= 1'b1;
                            state_q     <= ST_ON;
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end

                ST_GAP: begin
                    if (tick_i) begin
                        if (tick_cnt_q == GAP_LAST) begin
                            tick_cnt_q   <= '0;
                            blink_idx_q  <= '0;
                            frame_done_q <= 1'b1;
                            // enable/count are only looked at here, so a
                            // running frame always completes untouched.
                            if (start_req) begin
                                total_q <= count_i;
                                led_q   <= 1'b1;
                                state_q <= ST_ON;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_o        = led_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign blink_idx_o  = blink_idx_q;

    // Structural invariants of the registered outputs.
    a_led_is_on_state : assert property (@(posedge clock_i) disable iff (!reset_n_i)
        led_q == (state_q == ST_ON));
    a_busy_is_active : assert property (@(posedge clock_i) disable iff (!reset_n_i)
        busy_q == (state_q != ST_IDLE));
    a_done_one_cycle : assert property (@(posedge clock_i) disable iff (!reset_n_i)
        frame_done_q |=> !frame_done_q);
    a_idx_in_range : assert property (@(posedge clock_i) disable iff (!reset_n_i)
        busy_q |-> (blink_idx_q <= total_q - CNT_W'(1)));

endmodule
